// File: rtl/mult_pkg.sv
// Shared types and helpers for the tile-based sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TILE_W = 2;

    // Bit offset of the partial product for digit pair (i, j).
    function automatic int unsigned tile_shift(input int unsigned i, input int unsigned j);
        return TILE_W * (i + j);
    endfunction

endpackage

// File: rtl/mult2x2_tile.sv
// Exact combinational 2x2 unsigned product tile, shared by the sequencer.
module mult2x2_tile (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    assign p = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/mult_tile_sequencer.sv
// WIDTH x WIDTH unsigned multiplier: walks all D*D digit pairs through one
// 2x2 tile, one per cycle, accumulating shifted partials.
module mult_tile_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("mult_tile_sequencer: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]   i_q, j_q;
    logic [PW-1:0]   acc, acc_nxt, part;
    logic [1:0]      a_dig, b_dig;
    logic [3:0]      tile_p;
    logic            last;

    assign a_dig = a_q[TILE_W*int'(i_q) +: TILE_W];
    assign b_dig = b_q[TILE_W*int'(j_q) +: TILE_W];
    assign last  = (i_q == IW'(D-1)) && (j_q == IW'(D-1));

    mult2x2_tile u_tile (
        .a (a_dig),
        .b (b_dig),
        .p (tile_p)
    );

    assign part    = PW'(tile_p) << tile_shift(32'(i_q), 32'(j_q));
    assign acc_nxt = acc + part;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            acc   <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= in_b;
                        acc <= '0;
                        i_q <= '0;
                        j_q <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    // i is the inner digit index; j advances when i wraps
                    if (last) begin
                        out_p <= acc_nxt;
                        i_q   <= '0;
                        j_q   <= '0;
                    end else if (i_q == IW'(D-1)) begin
                        i_q <= '0;
                        j_q <= j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_tile_sequencer.sv
// Directed and randomized checks of mult_tile_sequencer at WIDTH=2/8/16 plus standalone tile.
module tb_mult_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else npass++;
    endtask

    // standalone tile
    logic [1:0] ta, tb;
    logic [3:0] tp;
    mult2x2_tile u_tile (.a(ta), .b(tb), .p(tp));

    // WIDTH=8 instance, own reset
    logic        rst8, iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    mult_tile_sequencer #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(busy8)
    );

    // WIDTH=2 and WIDTH=16 instances share a reset
    logic        rst_o;
    logic        iv2, ir2, ov2, or2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    mult_tile_sequencer #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst_o), .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
        .out_valid(ov2), .out_ready(or2), .out_p(p2), .busy(busy2)
    );

    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    mult_tile_sequencer #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst_o), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .out_valid(ov16), .out_ready(or16), .out_p(p16), .busy(busy16)
    );

    // One WIDTH=8 operation; called at a negedge while idle. Holds out_ready low
    // for 'hold' cycles in DONE, checking the result stays put.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                       output logic [15:0] p, output int lat);
        int n;
        logic [15:0] exp;
        exp = 16'(a) * 16'(b);
        n = 0;
        while (!ir8 && n < 100) begin @(negedge clk); n++; end
        chk("op8_ready", ir8, 1);
        iv8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        iv8 = 1'b0; a8 = ~a; b8 = ~b;
        lat = 1;
        while (!ov8 && lat < 100) begin @(negedge clk); lat++; end
        chk("op8_done", ov8, 1);
        for (int k = 0; k < hold; k++) begin
            chk("hold_p", p8, exp);
            chk("hold_inrdy", ir8, 0);
            chk("hold_ov", ov8, 1);
            @(negedge clk);
        end
        p = p8;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("op8_ov_low", ov8, 0);
        chk("op8_retain", p8, p);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        rst8 = 1'b1; rst_o = 1'b1;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
        iv2 = 0; or2 = 0; a2 = 0; b2 = 0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0;
        ta = 0; tb = 0;
        repeat (2) @(negedge clk);
        chk("rst_inrdy", ir8, 1);
        chk("rst_ov", ov8, 0);
        chk("rst_p", p8, 0);
        chk("rst_busy", busy8, 0);
        rst8 = 1'b0; rst_o = 1'b0;
        @(negedge clk);

        fork
            begin : t_w8
                logic [15:0] p;
                int lat, n, hs;
                logic got;
                logic [7:0] ra, rb;

                op8(8'd255, 8'd255, 0, p, lat);
                chk("ff_lat", lat, 17);
                chk("ff_p", p, 65025);
                op8(8'd0, 8'd200, 0, p, lat);
                chk("zero_p", p, 0);
                op8(8'd1, 8'd128, 0, p, lat);
                chk("one_p", p, 128);

                op8(8'd173, 8'd94, 5, p, lat);
                chk("hold_final", p, 16262);

                // operands offered during RUN must be ignored
                iv8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
                @(negedge clk);
                a8 = 8'd100; b8 = 8'd100;
                n = 0;
                while (!ov8 && n < 100) begin @(negedge clk); n++; end
                chk("t4_first", p8, 63);
                chk("t4_inrdy", ir8, 0);
                or8 = 1'b1;
                @(negedge clk);
                or8 = 1'b0;
                chk("t4_idle_rdy", ir8, 1);
                chk("t4_ov_low", ov8, 0);
                @(negedge clk);
                chk("t4_accepted", busy8, 1);
                iv8 = 1'b0;
                lat = 1;
                while (!ov8 && lat < 100) begin @(negedge clk); lat++; end
                chk("t4_lat", lat, 17);
                chk("t4_second", p8, 10000);
                or8 = 1'b1;
                @(negedge clk);
                or8 = 1'b0;

                // reset during RUN step 7
                iv8 = 1'b1; a8 = 8'd50; b8 = 8'd60;
                @(negedge clk);
                iv8 = 1'b0;
                repeat (7) @(negedge clk);
                chk("t5_running", busy8, 1);
                rst8 = 1'b1;
                @(negedge clk);
                rst8 = 1'b0;
                chk("t5_inrdy", ir8, 1);
                chk("t5_ov", ov8, 0);
                chk("t5_p", p8, 0);
                chk("t5_busy", busy8, 0);
                repeat (20) @(negedge clk);
                chk("t5_no_out", ov8, 0);
                op8(8'd12, 8'd13, 0, p, lat);
                chk("t5_after", p, 156);

                // random back-to-back with random out_ready
                hs = 0;
                for (int op = 0; op < 1000; op++) begin
                    ra = 8'($urandom); rb = 8'($urandom);
                    n = 0;
                    while (!ir8 && n < 100) begin @(negedge clk); n++; end
                    iv8 = 1'b1; a8 = ra; b8 = rb;
                    @(negedge clk);
                    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
                    got = 1'b0; n = 0;
                    while (!got && n < 300) begin
                        or8 = ($urandom % 4) != 0;
                        if (ov8 && or8) begin
                            chk("rnd8", p8, 16'(ra) * 16'(rb));
                            got = 1'b1; hs++;
                        end
                        @(negedge clk);
                        n++;
                    end
                    or8 = 1'b0;
                    if (!got) chk("rnd8_timeout", 0, 1);
                end
                chk("rnd8_count", hs, 1000);
            end

            begin : t_w2
                int lat;
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 4; y++) begin
                        ta = 2'(x); tb = 2'(y);
                        #1;
                        chk("tile", tp, 4'(x) * 4'(y));
                    end
                for (int x = 3; x >= 0; x--)
                    for (int y = 3; y >= 0; y--) begin
                        @(negedge clk);
                        iv2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
                        @(negedge clk);
                        iv2 = 1'b0;
                        lat = 1;
                        while (!ov2 && lat < 20) begin @(negedge clk); lat++; end
                        if (x == 3 && y == 3) chk("w2_lat", lat, 2);
                        chk("w2_p", p2, 4'(x) * 4'(y));
                        or2 = 1'b1;
                        @(negedge clk);
                        or2 = 1'b0;
                    end
            end

            begin : t_w16
                logic [15:0] ra, rb;
                logic got;
                int n, hs;
                hs = 0;
                for (int op = 0; op < 200; op++) begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    if (op == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
                    n = 0;
                    while (!ir16 && n < 300) begin @(negedge clk); n++; end
                    iv16 = 1'b1; a16 = ra; b16 = rb;
                    @(negedge clk);
                    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
                    got = 1'b0; n = 0;
                    while (!got && n < 400) begin
                        or16 = ($urandom % 4) != 0;
                        if (ov16 && or16) begin
                            chk("rnd16", p16, 32'(ra) * 32'(rb));
                            got = 1'b1; hs++;
                        end
                        @(negedge clk);
                        n++;
                    end
                    or16 = 1'b0;
                    if (!got) chk("rnd16_timeout", 0, 1);
                end
                chk("rnd16_count", hs, 200);
            end
        join

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
